// File: rtl/fetch_pc_pkg.sv
// Shared types and constants for the fetch stage and the fetch->decode pipeline register.
package fetch_pc_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StHold  = 2'd1,
    StDrain = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic        exc;
  } fetch_data_t;

endpackage

// File: rtl/fetch_pc.sv
// Fetch PC register and single-outstanding instruction-bus sequencer with redirect drain.
// Optional misaligned-target exception: define FETCH_MISALIGN_EXC_EN.
module fetch_pc
  import fetch_pc_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_redirect,
  input  logic [63:0] i_redirect_target,
  input  logic        i_stall,
  output logic        o_ireq_valid,
  output logic [63:0] o_ireq_addr,
  input  logic        i_idata_ok,
  input  logic [31:0] i_idata,
  output logic        o_out_valid,
  output logic [63:0] o_out_pc,
  output logic [31:0] o_out_instr,
  output logic        o_out_exc
);

  fetch_state_t r_state, w_state_next;
  logic [63:0]  r_pc, w_pc_next;
  logic [63:0]  r_req_addr, w_req_addr_next;
  logic         r_out_valid, w_out_valid_next;
  fetch_data_t  r_slot, w_slot_next;

  logic [63:0]  w_tgt;
  logic         w_tgt_misalign;
  logic [63:0]  w_drain_pc;
  logic         w_drain_misalign;

  // PC that the drain resolves to: a same-cycle redirect overrides the stored pc.
  assign w_drain_pc = i_redirect ? w_tgt : r_pc;

`ifdef FETCH_MISALIGN_EXC_EN
  assign w_tgt            = i_redirect_target;
  assign w_tgt_misalign   = |i_redirect_target[1:0];
  assign w_drain_misalign = |w_drain_pc[1:0];
`else
  assign w_tgt            = i_redirect_target & ~64'h3;
  assign w_tgt_misalign   = 1'b0;
  assign w_drain_misalign = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StFetch;
      r_pc        <= RESET_PC;
      r_req_addr  <= RESET_PC;
      r_out_valid <= 1'b0;
      r_slot      <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_req_addr  <= w_req_addr_next;
      r_out_valid <= w_out_valid_next;
      r_slot      <= w_slot_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_req_addr_next  = r_req_addr;
    w_out_valid_next = r_out_valid;
    w_slot_next      = r_slot;
    unique case (r_state)
      StFetch: begin
        if (i_redirect) begin
          w_out_valid_next = 1'b0;
          w_pc_next        = w_tgt;
          if (!i_idata_ok) begin
            // Bus cannot cancel: keep the old address up until its response arrives.
            w_state_next = StDrain;
          end else if (w_tgt_misalign) begin
            w_state_next     = StHold;
            w_out_valid_next = 1'b1;
            w_slot_next      = '{pc: w_tgt, raw_instr: NOP_INSTR, exc: 1'b1};
          end else begin
            w_req_addr_next = w_tgt;
          end
        end else if (i_idata_ok) begin
          w_state_next     = StHold;
          w_out_valid_next = 1'b1;
          w_slot_next      = '{pc: r_req_addr, raw_instr: i_idata, exc: 1'b0};
          w_pc_next        = r_req_addr + 64'd4;
        end
      end
      StHold: begin
        if (i_redirect) begin
          w_pc_next = w_tgt;
          if (w_tgt_misalign) begin
            w_out_valid_next = 1'b1;
            w_slot_next      = '{pc: w_tgt, raw_instr: NOP_INSTR, exc: 1'b1};
          end else begin
            w_out_valid_next = 1'b0;
            w_req_addr_next  = w_tgt;
            w_state_next     = StFetch;
          end
        end else if (!i_stall) begin
          w_out_valid_next = 1'b0;
          w_req_addr_next  = r_pc;
          w_state_next     = StFetch;
        end
      end
      StDrain: begin
        if (i_redirect) begin
          w_out_valid_next = 1'b0;
          w_pc_next        = w_tgt;
        end
        if (i_idata_ok) begin
          if (w_drain_misalign) begin
            w_state_next     = StHold;
            w_out_valid_next = 1'b1;
            w_slot_next      = '{pc: w_drain_pc, raw_instr: NOP_INSTR, exc: 1'b1};
          end else begin
            w_req_addr_next = w_drain_pc;
            w_state_next    = StFetch;
          end
        end
      end
      default: begin
        w_state_next     = StFetch;
        w_out_valid_next = 1'b0;
        w_req_addr_next  = r_pc;
      end
    endcase
  end

  always_comb begin
    o_ireq_valid = (r_state == StFetch) || (r_state == StDrain);
    o_ireq_addr  = r_req_addr;
    o_out_valid  = r_out_valid;
    o_out_pc     = r_slot.pc;
    o_out_instr  = r_slot.raw_instr;
    o_out_exc    = r_slot.exc;
  end

endmodule
